seq_addsub_unit: RTL and testbench
==================================

Name: seq_addsub_unit

Overview:
- Multi-cycle, parametrised adder/subtractor for the ALU datapath. Successor to the single-cycle 64-bit subtractor.
- Processes WIDTH-bit operands in CHUNK-bit slices, one slice per clock, rippling carry through a register, so the carry chain per cycle is CHUNK bits.
- Adds an add/sub mode, a start/busy/done handshake, and Y86-style condition flags: zero, sign, overflow, carry/borrow.

Parameters:
- WIDTH, 64, operand/result width in bits.
- CHUNK, 8, slice width per cycle; must divide WIDTH. N = WIDTH/CHUNK cycles per operation.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new operation; sampled only when not busy.
- mode  in  1  0 = add (a+b), 1 = subtract (a-b); sampled with start.
- a  in  WIDTH  operand A, two's complement; sampled with start.
- b  in  WIDTH  operand B, two's complement; sampled with start.
- busy  out  1  high while an operation is in progress.
- done  out  1  one-cycle pulse when result and flags become valid.
- result  out  WIDTH  sum or difference, modulo 2^WIDTH.
- cb  out  1  add: carry-out; sub: borrow, i.e. unsigned a < b (= NOT carry-out).
- overflow  out  1  signed overflow.
- zero  out  1  result == 0.
- sign  out  1  result[WIDTH-1].

Behaviour:
- Reset (rst=1 at a clock edge):
  - state = IDLE; busy, done, result, cb, overflow, zero, sign all 0; slice counter 0.
  - rst overrides start.
  - rst mid-operation aborts it: no done pulse, outputs cleared.
- IDLE state:
  - busy = 0.
  - start=1 at an edge: latch a; latch b (or ~b if mode=1); latch mode; carry register = mode; counter = 0; go to RUN.
- RUN state:
  - busy = 1.
  - Each edge adds slice[counter] of A, slice[counter] of B' and the carry register.
  - The CHUNK-bit sum is written into the internal accumulator at that slice position.
  - The carry register takes the slice carry-out; counter increments.
  - start is ignored throughout RUN.
  - On the edge that processes slice N-1:
    - Load result from the full accumulator.
    - Set flags:
      - cb = final carry for add, ~final carry for sub.
      - overflow = (sA == sB') && (sR != sA), where sA, sB', sR are the MSBs of the latched A, the (possibly inverted) B' and the result.
      - zero and sign from the result.
    - done = 1; go to DONE.
- DONE state (one cycle):
  - busy = 0, done = 1.
  - start=1 in this cycle is accepted exactly as in IDLE (back-to-back operation); otherwise return to IDLE.
- Latency and throughput:
  - If start is sampled at edge T0, done is high during the cycle following edge T0+N.
  - Throughput is one operation per N+1 cycles.
- Output holding:
  - result and flags change only on the edge that raises done, or on reset.
  - They hold their values in IDLE and RUN until the next completion.
  - done is high for exactly one cycle per completed operation.
- Width rules:
  - Operand and intermediate registers are WIDTH bits; the carry register is 1 bit.
  - No sign extension; wrap-around is modulo 2^WIDTH.
- Operand timing: a, b and mode may change freely after the start edge; only the latched copies are used.

Test Plan:
- WIDTH=64, CHUNK=8, subtract: a = b = 0xFFFFFFFFFFFFFFFF, start pulse at T0 -> done exactly 8 cycles later; result=0, zero=1, cb=0, overflow=0, sign=0; busy high for the 8 cycles between.
- Subtract: a=0x7FFFFFFFFFFFFFFF, b=0xFFFFFFFFFFFFFFE1 (-31) -> result=0x800000000000001E, overflow=1, sign=1, cb=1 (unsigned a<b), zero=0.
- Add: a=0xFFFFFFFFFFFFFFFF, b=0x0000000000000001 -> result=0, cb=1, zero=1, overflow=0. Then add a=0x7FFFFFFFFFFFFFFF, b=1 -> result=0x8000000000000000, overflow=1, cb=0.
- Start ignored while busy: start sub 10-3; re-pulse start with a=100, b=1 at cycles 2 and 5 -> exactly one done; result=7. Then start held high during DONE -> second operation begins immediately; its done arrives 9 cycles after the first.
- Reset mid-operation: rst=1 for one cycle at cycle 4 of a RUN -> next cycle busy=0, done=0, result=0, all flags 0. No done pulse ever appears for the aborted operation. A following start completes normally.
- Parameter sweep WIDTH=16, CHUNK=4, subtract: a=0x8000, b=0x0001 -> result=0x7FFF, overflow=1, cb=0, sign=0, done 4 cycles after start. Randomised add/sub (1000 vectors) against a behavioural a±b model for both configurations.

Source files
------------

// File: rtl/seq_addsub_unit_if.sv
// Handshake and operand/result bundle for the sequential add/subtract unit.
// The master issues operations; the slave (the unit itself) reports status,
// the result and the condition flags.
interface seq_addsub_unit_if #(
   parameter int WIDTH = 64
);
   logic             start;
   logic             mode;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             cb;
   logic             overflow;
   logic             zero;
   logic             sign;

   modport master (
      output start, mode, a, b,
      input  busy, done, result, cb, overflow, zero, sign
   );

   modport slave (
      input  start, mode, a, b,
      output busy, done, result, cb, overflow, zero, sign
   );
endinterface

// File: rtl/seq_addsub_unit.sv
// Multi-cycle adder/subtractor. Operands are consumed CHUNK bits per clock,
// least significant slice first, with the carry rippling through a 1-bit
// register. Subtraction is a + ~b + 1 (carry register preset to 1).
// Produces the result plus zero/sign/overflow/carry-borrow flags and a
// start/busy/done handshake. CHUNK must divide WIDTH and be smaller than it.
module seq_addsub_unit #(
   parameter int WIDTH = 64,
   parameter int CHUNK = 8
) (
   input  logic            clk,
   input  logic            rst,
   seq_addsub_unit_if.slave bus
);

   localparam int N     = WIDTH / CHUNK;
   localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_q, state_d;

   // Operands shift right one slice per cycle so the active slice is always
   // at the bottom; finished slices shift into the top of the accumulator.
   logic [WIDTH-1:0]       a_q;
   logic [WIDTH-1:0]       b_q;      // b, or ~b when subtracting
   logic [WIDTH-CHUNK-1:0] acc_q;    // completed slices, upper-aligned
   logic                   carry_q;
   logic                   mode_q;
   logic [CNT_W-1:0]       cnt_q;

   logic [WIDTH-1:0] result_q;
   logic             cb_q;
   logic             ovf_q;
   logic             zero_q;
   logic             sign_q;

   logic             accept;
   logic             last;
   logic [CHUNK:0]   slice_sum;
   logic [WIDTH-1:0] full_sum;

   // A new operation may start from IDLE or DONE, never mid-run.
   assign accept    = bus.start && (state_q != RUN);
   assign last      = (state_q == RUN) && (cnt_q == LAST);
   assign slice_sum = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]}
                    + {{CHUNK{1'b0}}, carry_q};
   // On the final slice this is the complete WIDTH-bit result.
   assign full_sum  = {slice_sum[CHUNK-1:0], acc_q};

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = RUN;
         RUN:     if (cnt_q == LAST) state_d = DONE;
         DONE:    state_d = bus.start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Slice counter.
   always_ff @(posedge clk) begin
      if (rst)                  cnt_q <= '0;
      else if (accept)          cnt_q <= '0;
      else if (state_q == RUN)  cnt_q <= cnt_q + CNT_W'(1);
   end

   // Operand latch and per-slice ripple; mode presets the carry-in.
   always_ff @(posedge clk) begin
      if (accept) begin
         a_q     <= bus.a;
         b_q     <= bus.mode ? ~bus.b : bus.b;
         carry_q <= bus.mode;
         mode_q  <= bus.mode;
      end else if (state_q == RUN) begin
         a_q     <= a_q >> CHUNK;
         b_q     <= b_q >> CHUNK;
         acc_q   <= full_sum[WIDTH-1:CHUNK];
         carry_q <= slice_sum[CHUNK];
      end
   end

   // Result and flags update only on completion; sign bits of the operands
   // are the top bits of the final slice still sitting in a_q/b_q.
   always_ff @(posedge clk) begin
      if (rst) begin
         result_q <= '0;
         cb_q     <= 1'b0;
         ovf_q    <= 1'b0;
         zero_q   <= 1'b0;
         sign_q   <= 1'b0;
      end else if (last) begin
         result_q <= full_sum;
         cb_q     <= slice_sum[CHUNK] ^ mode_q;
         ovf_q    <= (a_q[CHUNK-1] == b_q[CHUNK-1]) &&
                     (slice_sum[CHUNK-1] != a_q[CHUNK-1]);
         zero_q   <= (full_sum == '0);
         sign_q   <= slice_sum[CHUNK-1];
      end
   end

   assign bus.busy     = (state_q == RUN);
   assign bus.done     = (state_q == DONE);
   assign bus.result   = result_q;
   assign bus.cb       = cb_q;
   assign bus.overflow = ovf_q;
   assign bus.zero     = zero_q;
   assign bus.sign     = sign_q;

endmodule

// File: tb/tb_seq_addsub_unit.sv
// Scoreboard bench for seq_addsub_unit in two configurations (64/8 and 16/4).
// Drivers push expected results computed by a wide-integer model; monitors
// pop and compare whenever done is seen.
module tb_seq_addsub_unit;

   typedef struct packed {
      logic [63:0] r;
      logic        cb;
      logic        ov;
      logic        z;
      logic        s;
   } exp_t;

   logic clk = 1'b0;
   logic rst64, rst16;
   int   nvec = 0;
   int   nmis = 0;
   exp_t q64[$];
   exp_t q16[$];

   always #5 clk = ~clk;

   seq_addsub_unit_if #(.WIDTH(64)) if64 ();
   seq_addsub_unit_if #(.WIDTH(16)) if16 ();

   seq_addsub_unit #(.WIDTH(64), .CHUNK(8)) u64 (.clk(clk), .rst(rst64), .bus(if64.slave));
   seq_addsub_unit #(.WIDTH(16), .CHUNK(4)) u16 (.clk(clk), .rst(rst16), .bus(if16.slave));

   // Reference: unsigned and signed views of the operands as wide integers.
   function automatic exp_t model(input int w, input logic [63:0] a,
                                  input logic [63:0] b, input logic m);
      exp_t e;
      logic [63:0] mask;
      logic [64:0] ua, ub, us;
      logic signed [66:0] sa, sb, sr, lim;
      mask = (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
      ua = {1'b0, a & mask};
      ub = {1'b0, b & mask};
      us = m ? (ua - ub) : (ua + ub);
      e.r  = us[63:0] & mask;
      e.cb = m ? (ua < ub) : us[w];
      lim = 67'sd1 <<< (w - 1);
      sa = $signed({2'b00, ua});
      sb = $signed({2'b00, ub});
      if (a[w-1]) sa = sa - (lim <<< 1);
      if (b[w-1]) sb = sb - (lim <<< 1);
      sr = m ? (sa - sb) : (sa + sb);
      e.ov = (sr >= lim) || (sr < -lim);
      e.z  = (e.r == 64'd0);
      e.s  = e.r[w-1];
      return e;
   endfunction

   task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] req);
      nvec++;
      if (act !== req) begin
         nmis++;
         $display("FAIL %s: got %h required %h", nm, act, req);
      end
   endtask

   task automatic issue64(input logic [63:0] a, input logic [63:0] b, input logic m);
      @(negedge clk);
      if64.start = 1'b1; if64.a = a; if64.b = b; if64.mode = m;
      q64.push_back(model(64, a, b, m));
      @(negedge clk);
      if64.start = 1'b0; if64.a = {$urandom, $urandom}; if64.b = {$urandom, $urandom}; if64.mode = ~m;
   endtask

   task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic m);
      @(negedge clk);
      if16.start = 1'b1; if16.a = a; if16.b = b; if16.mode = m;
      q16.push_back(model(16, {48'd0, a}, {48'd0, b}, m));
      @(negedge clk);
      if16.start = 1'b0; if16.a = 16'($urandom); if16.b = 16'($urandom); if16.mode = ~m;
   endtask

   // Called just after issue: lat counts negedges since the start edge.
   task automatic wait64(output int lat, output int nb);
      lat = 1; nb = 0;
      while (!if64.done && lat < 64) begin
         if (if64.busy) nb++;
         @(negedge clk);
         lat++;
      end
      if (!if64.done) begin
         nvec++; nmis++;
         $display("FAIL timeout64: got no done after %0d cycles required done", lat);
      end
   endtask

   task automatic wait16(output int lat, output int nb);
      lat = 1; nb = 0;
      while (!if16.done && lat < 64) begin
         if (if16.busy) nb++;
         @(negedge clk);
         lat++;
      end
      if (!if16.done) begin
         nvec++; nmis++;
         $display("FAIL timeout16: got no done after %0d cycles required done", lat);
      end
   endtask

   // Monitors.
   initial begin
      exp_t g, e;
      forever begin
         @(negedge clk);
         if (if64.done) begin
            nvec++;
            if (q64.size() == 0) begin
               nmis++;
               $display("FAIL done64: got unexpected done required no pending op");
            end else begin
               e = q64.pop_front();
               g = '{if64.result, if64.cb, if64.overflow, if64.zero, if64.sign};
               if (g !== e) begin
                  nmis++;
                  $display("FAIL res64: got r=%h cb=%b ov=%b z=%b s=%b required r=%h cb=%b ov=%b z=%b s=%b",
                           g.r, g.cb, g.ov, g.z, g.s, e.r, e.cb, e.ov, e.z, e.s);
               end
            end
         end
      end
   end

   initial begin
      exp_t g, e;
      forever begin
         @(negedge clk);
         if (if16.done) begin
            nvec++;
            if (q16.size() == 0) begin
               nmis++;
               $display("FAIL done16: got unexpected done required no pending op");
            end else begin
               e = q16.pop_front();
               g = '{{48'd0, if16.result}, if16.cb, if16.overflow, if16.zero, if16.sign};
               if (g !== e) begin
                  nmis++;
                  $display("FAIL res16: got r=%h cb=%b ov=%b z=%b s=%b required r=%h cb=%b ov=%b z=%b s=%b",
                           g.r, g.cb, g.ov, g.z, g.s, e.r, e.cb, e.ov, e.z, e.s);
               end
            end
         end
      end
   end

   initial begin
      int lat, nb, nd, d1, d2;
      logic [63:0] ra, rb;
      logic [15:0] sa16, sb16;
      logic rm;

      rst64 = 1'b1; rst16 = 1'b1;
      if64.start = 1'b0; if64.mode = 1'b0; if64.a = '0; if64.b = '0;
      if16.start = 1'b0; if16.mode = 1'b0; if16.a = '0; if16.b = '0;
      repeat (3) @(negedge clk);
      rst64 = 1'b0; rst16 = 1'b0;
      chk("reset64", {if64.busy, if64.done, if64.cb, if64.overflow, if64.zero, if64.sign, if64.result}, '0);
      chk("reset16", {if16.busy, if16.done, if16.cb, if16.overflow, if16.zero, if16.sign, if16.result}, '0);

      // Equal operands subtract to zero; latency and busy window.
      issue64(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
      wait64(lat, nb);
      chk("latency64", 72'(lat), 72'd9);
      chk("busy64", 72'(nb), 72'd8);

      issue64(64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFE1, 1'b1);
      wait64(lat, nb);
      chk("sub_ovf_r", 72'(if64.result), 72'h8000_0000_0000_001E);
      issue64(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
      wait64(lat, nb);
      issue64(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
      wait64(lat, nb);
      chk("add_ovf_flags", {69'd0, if64.overflow, if64.cb, if64.sign}, 72'b101);

      // Starts while busy are ignored; start held into DONE chains an op.
      issue64(64'd10, 64'd3, 1'b1);
      nd = 0; d1 = 0; d2 = 0;
      for (int i = 2; i <= 20; i++) begin
         @(negedge clk);
         if (if64.done) begin
            nd++;
            if (nd == 1) d1 = i; else d2 = i;
         end
         if (i == 2 || i == 5) begin
            if64.start = 1'b1; if64.a = 64'd100; if64.b = 64'd1; if64.mode = 1'b0;
         end else if (i == 3 || i == 6 || i == 10) begin
            if64.start = 1'b0;
         end else if (i == 8) begin
            if64.start = 1'b1; if64.a = 64'd20; if64.b = 64'd5; if64.mode = 1'b0;
            q64.push_back(model(64, 64'd20, 64'd5, 1'b0));
         end
      end
      chk("b2b_ndone", 72'(nd), 72'd2);
      chk("b2b_first", 72'(d1), 72'd9);
      chk("b2b_gap", 72'(d2 - d1), 72'd9);

      // Reset in the middle of a run aborts it silently.
      issue64(64'h1234, 64'h0FFF_0000_0000_0000, 1'b1);
      repeat (3) @(negedge clk);
      rst64 = 1'b1;
      void'(q64.pop_back());
      @(negedge clk);
      rst64 = 1'b0;
      chk("abort_clear", {if64.busy, if64.done, if64.cb, if64.overflow, if64.zero, if64.sign, if64.result}, '0);
      nd = 0;
      repeat (12) begin
         @(negedge clk);
         if (if64.done) nd++;
      end
      chk("abort_no_done", 72'(nd), 72'd0);
      issue64(64'd5, 64'd9, 1'b1);
      wait64(lat, nb);
      chk("after_abort_lat", 72'(lat), 72'd9);

      // Narrow configuration.
      issue16(16'h8000, 16'h0001, 1'b1);
      wait16(lat, nb);
      chk("latency16", 72'(lat), 72'd5);
      chk("busy16", 72'(nb), 72'd4);
      chk("sub16_r", 72'(if16.result), 72'h7FFF);

      for (int i = 0; i < 1000; i++) begin
         ra = {$urandom, $urandom};
         rb = ($urandom_range(0, 7) == 0) ? ra : {$urandom, $urandom};
         rm = 1'($urandom);
         issue64(ra, rb, rm);
         wait64(lat, nb);
      end
      for (int i = 0; i < 1000; i++) begin
         sa16 = 16'($urandom);
         sb16 = ($urandom_range(0, 7) == 0) ? sa16 : 16'($urandom);
         rm = 1'($urandom);
         issue16(sa16, sb16, rm);
         wait16(lat, nb);
      end

      repeat (3) @(negedge clk);
      chk("pending64", 72'(q64.size()), 72'd0);
      chk("pending16", 72'(q16.size()), 72'd0);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
